// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//
// Age-ordered reservation station in front of the single-cycle ALU. Slots are
// kept compacted with slot 0 the oldest. Missing source operands are captured
// from the common data bus; each cycle the oldest entry with both operands
// ready is issued through registered outputs with a one-cycle request pulse.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   flush_i                   squash all entries (dispatch/CDB that cycle dropped)
//   dispatch_*                incoming instruction, valid/ready handshake
//   cdb_valid_i/tag_i/value_i common data bus broadcast
//   alu_request_o             one-cycle issue pulse
//   pc_o/inst_o/rs1_value_o/rs2_value_o/rd_tag_o  issued instruction fields
//   count_o                   current occupancy
// ---------------------------------------------------------------------------
module alu_reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       dispatch_valid_i,
    output logic                       dispatch_ready_o,
    input  logic [31:0]                dispatch_pc_i,
    input  logic [31:0]                dispatch_inst_i,
    input  logic [TAG_W-1:0]           dispatch_rd_tag_i,
    input  logic                       dispatch_rs1_ready_i,
    input  logic                       dispatch_rs2_ready_i,
    input  logic [31:0]                dispatch_rs1_value_i,
    input  logic [31:0]                dispatch_rs2_value_i,
    input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
    input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [31:0]                cdb_value_i,
    output logic                       alu_request_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                rs1_value_o,
    output logic [31:0]                rs2_value_o,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] rd_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
    } slot_t;

    // Capture a CDB broadcast into any waiting operand of one slot.
    function automatic slot_t wake(input slot_t s, input logic vld,
                                   input logic [TAG_W-1:0] tag,
                                   input logic [31:0] value);
        slot_t r;
        r = s;
        if (vld && s.valid) begin
            if (!s.rs1_rdy && s.rs1_tag == tag) begin
                r.rs1_rdy = 1'b1;
                r.rs1_val = value;
            end
            if (!s.rs2_rdy && s.rs2_tag == tag) begin
                r.rs2_rdy = 1'b1;
                r.rs2_val = value;
            end
        end
        return r;
    endfunction

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    // One spare invalid element on top so the shift-down never indexes past the end.
    slot_t            woke   [DEPTH+1];
    slot_t            new_slot;

    logic [CNT_W-1:0] count_q, count_d;
    logic             req_q, req_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      rs1_out_q, rs1_out_d;
    logic [31:0]      rs2_out_q, rs2_out_d;
    logic [TAG_W-1:0] rd_tag_q, rd_tag_d;

    logic             sel_found;
    logic             issue;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic [CNT_W-1:0] wr_idx;

    assign dispatch_ready_o = (count_q < CNT_W'(DEPTH));
    assign accept           = dispatch_valid_i && dispatch_ready_o && !flush_i;
    assign issue            = sel_found && !flush_i;
    // After an issue everything shifts down one, so the first free slot moves too.
    assign wr_idx           = count_q - CNT_W'(issue);

    // Oldest eligible slot, judged on registered ready flags only.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_q[i].valid && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        new_slot         = '0;
        new_slot.valid   = 1'b1;
        new_slot.pc      = dispatch_pc_i;
        new_slot.inst    = dispatch_inst_i;
        new_slot.rd_tag  = dispatch_rd_tag_i;
        new_slot.rs1_rdy = dispatch_rs1_ready_i;
        new_slot.rs1_tag = dispatch_rs1_tag_i;
        new_slot.rs1_val = dispatch_rs1_value_i;
        new_slot.rs2_rdy = dispatch_rs2_ready_i;
        new_slot.rs2_tag = dispatch_rs2_tag_i;
        new_slot.rs2_val = dispatch_rs2_value_i;
        // Same-cycle CDB bypass for operands arriving not ready.
        if (cdb_valid_i && !dispatch_rs1_ready_i && dispatch_rs1_tag_i == cdb_tag_i) begin
            new_slot.rs1_rdy = 1'b1;
            new_slot.rs1_val = cdb_value_i;
        end
        if (cdb_valid_i && !dispatch_rs2_ready_i && dispatch_rs2_tag_i == cdb_tag_i) begin
            new_slot.rs2_rdy = 1'b1;
            new_slot.rs2_val = cdb_value_i;
        end

        for (int i = 0; i < DEPTH; i++) begin
            woke[i] = wake(slot_q[i], cdb_valid_i, cdb_tag_i, cdb_value_i);
        end
        woke[DEPTH] = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (issue && i >= int'(sel_idx)) begin
                slot_d[i] = woke[i+1];
            end else begin
                slot_d[i] = woke[i];
            end
            if (accept && CNT_W'(i) == wr_idx) begin
                slot_d[i] = new_slot;
            end
            if (flush_i) begin
                slot_d[i].valid = 1'b0;
            end
        end

        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(accept) - CNT_W'(issue);
        end

        req_d     = issue;
        pc_d      = pc_q;
        inst_d    = inst_q;
        rs1_out_d = rs1_out_q;
        rs2_out_d = rs2_out_q;
        rd_tag_d  = rd_tag_q;
        if (issue) begin
            pc_d      = slot_q[sel_idx].pc;
            inst_d    = slot_q[sel_idx].inst;
            rs1_out_d = slot_q[sel_idx].rs1_val;
            rs2_out_d = slot_q[sel_idx].rs2_val;
            rd_tag_d  = slot_q[sel_idx].rd_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i].valid <= 1'b0;
            end
            count_q   <= '0;
            req_q     <= 1'b0;
            pc_q      <= '0;
            inst_q    <= '0;
            rs1_out_q <= '0;
            rs2_out_q <= '0;
            rd_tag_q  <= '0;
        end else begin
            slot_q    <= slot_d;
            count_q   <= count_d;
            req_q     <= req_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            rs1_out_q <= rs1_out_d;
            rs2_out_q <= rs2_out_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    assign alu_request_o = req_q;
    assign pc_o          = pc_q;
    assign inst_o        = inst_q;
    assign rs1_value_o   = rs1_out_q;
    assign rs2_value_o   = rs2_out_q;
    assign rd_tag_o      = rd_tag_q;
    assign count_o       = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench for alu_reservation_station: directed scenarios followed
// by randomized traffic, checked against a queue-based reference model.
module tb_alu_reservation_station;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic clk;
    logic rst, flush;
    logic dv;
    logic [31:0] dpc, dinst;
    logic [TAG_W-1:0] drd;
    logic d1r, d2r;
    logic [31:0] d1v, d2v;
    logic [TAG_W-1:0] d1t, d2t;
    logic cv;
    logic [TAG_W-1:0] ct;
    logic [31:0] cval;

    logic dispatch_ready_o, alu_request_o;
    logic [31:0] pc_o, inst_o, rs1_value_o, rs2_value_o;
    logic [TAG_W-1:0] rd_tag_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    alu_reservation_station #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .reset_i(rst), .flush_i(flush),
        .dispatch_valid_i(dv), .dispatch_ready_o(dispatch_ready_o),
        .dispatch_pc_i(dpc), .dispatch_inst_i(dinst), .dispatch_rd_tag_i(drd),
        .dispatch_rs1_ready_i(d1r), .dispatch_rs2_ready_i(d2r),
        .dispatch_rs1_value_i(d1v), .dispatch_rs2_value_i(d2v),
        .dispatch_rs1_tag_i(d1t), .dispatch_rs2_tag_i(d2t),
        .cdb_valid_i(cv), .cdb_tag_i(ct), .cdb_value_i(cval),
        .alu_request_o(alu_request_o), .pc_o(pc_o), .inst_o(inst_o),
        .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
        .rd_tag_o(rd_tag_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, inst;
        logic [TAG_W-1:0] rd;
        logic r1, r2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0] v1, v2;
    } ent_t;

    ent_t q[$];
    logic e_req;
    logic [31:0] e_pc, e_inst, e_rs1, e_rs2;
    logic [TAG_W-1:0] e_rd;
    bit known = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        dv = 0; cv = 0; flush = 0; rst = 0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] inst, input logic [TAG_W-1:0] rd,
                        input logic r1, input logic [31:0] v1, input logic [TAG_W-1:0] t1,
                        input logic r2, input logic [31:0] v2, input logic [TAG_W-1:0] t2);
        dv = 1; dpc = pc; dinst = inst; drd = rd;
        d1r = r1; d1v = v1; d1t = t1;
        d2r = r2; d2v = v2; d2t = t2;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] value);
        cv = 1; ct = tag; cval = value;
    endtask

    // One clock: check the pre-edge handshake, advance the model, check outputs.
    task automatic cycle();
        int sel;
        bit acc;
        ent_t e;
        if (known) check("dispatch_ready", dispatch_ready_o, (q.size() < DEPTH));
        @(posedge clk);
        if (rst) begin
            q.delete();
            e_req = 0; e_pc = 0; e_inst = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
            known = 1;
        end else if (flush) begin
            q.delete();
            e_req = 0;
        end else begin
            acc = dv && (q.size() < DEPTH);
            sel = -1;
            foreach (q[i]) if (sel < 0 && q[i].r1 && q[i].r2) sel = i;
            if (sel >= 0) begin
                e_req = 1;
                e_pc = q[sel].pc; e_inst = q[sel].inst; e_rd = q[sel].rd;
                e_rs1 = q[sel].v1; e_rs2 = q[sel].v2;
                q.delete(sel);
            end else begin
                e_req = 0;
            end
            if (cv) begin
                foreach (q[i]) begin
                    if (!q[i].r1 && q[i].t1 == ct) begin q[i].r1 = 1; q[i].v1 = cval; end
                    if (!q[i].r2 && q[i].t2 == ct) begin q[i].r2 = 1; q[i].v2 = cval; end
                end
            end
            if (acc) begin
                e.pc = dpc; e.inst = dinst; e.rd = drd;
                e.r1 = d1r; e.t1 = d1t; e.v1 = d1v;
                e.r2 = d2r; e.t2 = d2t; e.v2 = d2v;
                if (cv && !e.r1 && e.t1 == ct) begin e.r1 = 1; e.v1 = cval; end
                if (cv && !e.r2 && e.t2 == ct) begin e.r2 = 1; e.v2 = cval; end
                q.push_back(e);
            end
        end
        #1;
        check("count", count_o, q.size());
        check("alu_request", alu_request_o, e_req);
        check("pc", pc_o, e_pc);
        check("inst", inst_o, e_inst);
        check("rs1_value", rs1_value_o, e_rs1);
        check("rs2_value", rs2_value_o, e_rs2);
        check("rd_tag", rd_tag_o, e_rd);
    endtask

    initial begin
        idle();
        dpc = 0; dinst = 0; drd = 0; d1r = 0; d2r = 0; d1v = 0; d2v = 0; d1t = 0; d2t = 0;
        ct = 0; cval = 0;
        rst = 1;
        cycle(); cycle();
        check("reset_count", count_o, 0);
        check("reset_req", alu_request_o, 0);
        idle();

        // ADDI with ready operands: request two edges after dispatch.
        disp(32'h100, 32'h00500093, 4'd1, 1, 32'd7, 0, 1, 32'd0, 0);
        cycle(); idle();
        cycle();
        check("t1_req", alu_request_o, 1);
        check("t1_pc", pc_o, 32'h100);
        check("t1_rs1", rs1_value_o, 32'd7);
        cycle();
        check("t1_count", count_o, 0);

        // Younger ready entry overtakes an older waiting one.
        disp(32'h200, 32'h00208133, 4'd2, 0, 0, 4'd3, 1, 32'h11, 0);
        cycle();
        disp(32'h204, 32'h003081b3, 4'd4, 1, 32'h22, 0, 1, 32'h33, 0);
        cycle(); idle();
        cycle();
        check("t2_b_first", pc_o, 32'h204);
        cdb(4'd3, 32'h55);
        cycle(); idle();
        cycle();
        check("t2_a_req", alu_request_o, 1);
        check("t2_a_rs1", rs1_value_o, 32'h55);
        cycle();

        // Fill the station waiting on tag 2, then release with one broadcast.
        for (int i = 0; i < DEPTH; i++) begin
            disp(32'h300 + 4 * i, 32'h13 + i, 4'(8 + i), 0, 0, 4'd2, 1, 32'(i), 0);
            cycle();
        end
        idle();
        check("t3_full_ready", dispatch_ready_o, 0);
        check("t3_full_count", count_o, DEPTH);
        cdb(4'd2, 32'hABC);
        cycle(); idle();
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            check("t3_order", pc_o, 32'h300 + 4 * i);
        end
        cycle();

        // Dispatch-time CDB bypass.
        disp(32'h400, 32'h40000033, 4'd6, 1, 32'h1, 0, 0, 0, 4'd5);
        cdb(4'd5, 32'hDEAD);
        cycle(); idle();
        cycle();
        check("t4_bypass", rs2_value_o, 32'hDEAD);
        cycle();

        // Flush with a concurrent dispatch.
        for (int i = 0; i < 3; i++) begin
            disp(32'h500 + 4 * i, 32'h33, 4'd7, 0, 0, 4'd9, 1, 0, 0);
            cycle();
        end
        disp(32'h600, 32'h33, 4'd7, 1, 32'h6, 0, 1, 32'h6, 0);
        flush = 1;
        cycle(); idle();
        check("t5_flush_count", count_o, 0);
        cdb(4'd9, 32'h9);
        cycle(); idle();
        cycle(); cycle();

        // Reset mid-stream with two entries waiting.
        disp(32'h700, 32'h33, 4'd3, 0, 0, 4'd12, 1, 0, 0);
        cycle();
        disp(32'h704, 32'h33, 4'd3, 0, 0, 4'd12, 1, 0, 0);
        cycle(); idle();
        rst = 1;
        cycle(); idle();
        check("t6_reset_pc", pc_o, 0);
        cdb(4'd12, 32'h12);
        cycle(); idle();
        cycle(); cycle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                disp($urandom, $urandom, 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 7)));
            if ($urandom_range(0, 9) < 4) cdb(4'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 99) == 0) flush = 1;
            if ($urandom_range(0, 299) == 0) rst = 1;
            cycle();
        end
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
